// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: control/status bundle between a scan controller (master) and scan_sequencer (slave)
//   start, stop, mode, dwell : controller -> sequencer requests and sweep configuration
//   pause                    : freeze request, present only with SCAN_SEQUENCER_PAUSE_EN
//   sel, sel_en              : decoder index and enable
//   busy, done, wrap         : sweep status and one-cycle event pulses
interface scan_sequencer_if #(parameter int DWELL_W = 8);
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_SEQUENCER_PAUSE_EN
  logic               pause;
`endif
  logic [3:0]         sel;
  logic               sel_en;
  logic               busy;
  logic               done;
  logic               wrap;
  modport master (
`ifdef SCAN_SEQUENCER_PAUSE_EN
    output pause,
`endif
    output start, stop, mode, dwell,
    input  sel, sel_en, busy, done, wrap
  );
  modport slave (
`ifdef SCAN_SEQUENCER_PAUSE_EN
    input  pause,
`endif
    input  start, stop, mode, dwell,
    output sel, sel_en, busy, done, wrap
  );
endinterface

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 4:16 decoder select through 0..LAST, holding each index dwell+1 cycles
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : scan_sequencer_if.slave (start/stop/mode/dwell[/pause] in, sel/sel_en/busy/done/wrap out)
//   Optional macro SCAN_SEQUENCER_PAUSE_EN adds bus.pause, which freezes sel and the dwell counter in ACTIVE.
module scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int LAST    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_sequencer_if.slave  bus
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam logic [3:0] LAST_SEL = LAST[3:0];
  logic [0:0]         state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               pause_w;
`ifdef SCAN_SEQUENCER_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (state_q == IDLE) begin
      // stop has priority over a coincident start
      if (bus.start && !bus.stop) begin
        state_d = ACTIVE;
        mode_d  = bus.mode;
        dwell_d = bus.dwell;
        cnt_d   = bus.dwell;
        sel_d   = 4'd0;
      end
    end else if (bus.stop) begin
      // abort overrides any coincident done/wrap event
      state_d = IDLE;
      sel_d   = 4'd0;
      cnt_d   = '0;
    end else if (!pause_w) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (sel_q != LAST_SEL) begin
        sel_d = sel_q + 4'd1;
        cnt_d = dwell_q;
      end else if (mode_q) begin
        sel_d  = 4'd0;
        cnt_d  = dwell_q;
        wrap_d = 1'b1;
      end else begin
        state_d = IDLE;
        sel_d   = 4'd0;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end
  // busy and sel_en are both the registered ACTIVE state, so sel_en implies busy by construction
  assign bus.sel    = sel_q;
  assign bus.sel_en = state_q;
  assign bus.busy   = state_q;
  assign bus.done   = done_q;
  assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: randomized and directed checks of scan_sequencer against an elapsed-time reference model
module tb_scan_sequencer;
  localparam int DWELL_W = 8;
  localparam int LAST    = 15;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  scan_sequencer_if #(.DWELL_W(DWELL_W)) bus();
  scan_sequencer #(.DWELL_W(DWELL_W), .LAST(LAST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic pause_r;
`ifdef SCAN_SEQUENCER_PAUSE_EN
  assign bus.pause = pause_r;
`endif
  bit m_act;
  bit m_mode;
  int m_dw;
  int m_el;
  bit m_done;
  bit m_wrap;
  function automatic int m_sel();
    return m_act ? (m_el / (m_dw + 1)) : 0;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] outs();
    return {24'd0, bus.sel, bus.sel_en, bus.busy, bus.done, bus.wrap};
  endfunction
  function automatic logic [31:0] exp_outs();
    logic [3:0] s;
    s = 4'(m_sel());
    return {24'd0, s, m_act, m_act, m_done, m_wrap};
  endfunction
  // one clock: advance the model from current inputs, then sample DUT 1 time unit after the edge
  task automatic tick(input string tag);
    int period;
    m_done = 0;
    m_wrap = 0;
    if (!m_act) begin
      if (bus.start && !bus.stop) begin
        m_act  = 1;
        m_mode = bus.mode;
        m_dw   = int'(bus.dwell);
        m_el   = 0;
      end
    end else if (bus.stop) begin
      m_act = 0;
    end else if (!pause_r) begin
      period = (m_dw + 1) * (LAST + 1);
      m_el++;
      if (m_el == period) begin
        if (m_mode) begin
          m_el   = 0;
          m_wrap = 1;
        end else begin
          m_act  = 0;
          m_done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check(tag, outs(), exp_outs());
  endtask
  task automatic launch(input bit md, input int dw);
    bus.start = 1'b1;
    bus.mode  = md;
    bus.dwell = DWELL_W'(dw);
    tick("launch");
    bus.start = 1'b0;
  endtask
  task automatic run_to_sel(input int s, input string tag);
    for (int i = 0; i < 5000 && !(m_act && m_sel() == s); i++) tick(tag);
  endtask
  task automatic run_to_idle(input string tag);
    for (int i = 0; i < 5000 && m_act; i++) tick(tag);
    tick(tag);
  endtask
  initial begin
    int en_cycles;
    bus.start = 0;
    bus.stop  = 0;
    bus.mode  = 0;
    bus.dwell = '0;
    pause_r   = 0;
    rst_n     = 0;
    #1;
    check("reset_outs", outs(), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held", outs(), 32'd0);
    rst_n = 1;
    tick("idle");
    // single sweep dwell=0: one index per cycle, then done
    launch(0, 0);
    run_to_idle("single_d0");
    // single sweep dwell=2: count enabled cycles independently of the model
    launch(0, 2);
    en_cycles = 1;
    for (int i = 0; i < 60 && bus.sel_en; i++) begin
      tick("single_d2");
      if (bus.sel_en) en_cycles++;
    end
    check("single_d2_len", en_cycles, 48);
    check("single_d2_done", {31'd0, bus.done}, 1);
    tick("after_done");
    // continuous dwell=1 for 70 cycles
    launch(1, 1);
    for (int i = 0; i < 69; i++) tick("cont_d1");
    // stop at sel=9 in continuous mode
    run_to_sel(9, "to_sel9");
    bus.stop = 1;
    tick("stop");
    bus.stop = 0;
    check("stop_idle", outs(), 32'd0);
    tick("post_stop");
    // start and stop together in IDLE
    bus.start = 1;
    bus.stop  = 1;
    tick("start_stop");
    bus.start = 0;
    bus.stop  = 0;
    tick("start_stop_idle");
    // start with different dwell while active is ignored
    launch(0, 1);
    run_to_sel(3, "to_sel3");
    bus.start = 1;
    bus.dwell = 8'd6;
    bus.mode  = 1;
    for (int i = 0; i < 5; i++) tick("restart_ign");
    bus.start = 0;
    run_to_idle("restart_ign");
    // stop coincident with end-of-sweep
    launch(0, 0);
    run_to_sel(LAST, "to_last");
    bus.stop = 1;
    tick("stop_at_end");
    bus.stop = 0;
    tick("stop_at_end_idle");
    // maximum dwell
    launch(0, 255);
    run_to_idle("dwell_max");
`ifdef SCAN_SEQUENCER_PAUSE_EN
    launch(0, 2);
    run_to_sel(4, "to_sel4");
    pause_r = 1;
    for (int i = 0; i < 5; i++) tick("pause");
    pause_r = 0;
    run_to_idle("pause_resume");
    pause_r = 1;
    tick("pause_idle");
    pause_r = 0;
`endif
    // async reset mid-sweep at sel=7
    launch(1, 1);
    run_to_sel(7, "to_sel7");
    #2;
    rst_n = 0;
    #1;
    check("async_rst", outs(), 32'd0);
    m_act = 0;
    @(posedge clk);
    #1;
    check("async_rst_hold", outs(), 32'd0);
    rst_n = 1;
    tick("post_rst");
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 7) == 0);
      bus.stop  = ($urandom_range(0, 59) == 0);
      bus.mode  = $urandom_range(0, 1);
      bus.dwell = DWELL_W'($urandom_range(0, 3));
`ifdef SCAN_SEQUENCER_PAUSE_EN
      pause_r = ($urandom_range(0, 9) == 0);
`endif
      tick("random");
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for the 4:16 one-hot line decoder.
- Steps a 4-bit select index through 0..LAST and holds each index for a programmable dwell time.
- Drives the decoder's index and enable inputs, so exactly one decoded line is active at a time during a sweep.
- Supports single-sweep and continuous modes, with a start/stop control interface and status pulses.

Parameters:
- DWELL_W, 8, width of the dwell count input and internal dwell counter.
- LAST, 15, final index of a sweep; legal range 1..15; sweep covers 0..LAST.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- stop  input  1  abort the sweep; sampled in IDLE and ACTIVE.
- mode  input  1  0 = single sweep, 1 = continuous; latched on accepted start.
- dwell  input  DWELL_W  hold time per index minus 1; latched on accepted start.
- sel  output  4  index to the decoder's 4-bit select input.
- sel_en  output  1  enable to the decoder.
- busy  output  1  high while ACTIVE.
- done  output  1  one-cycle pulse when a single sweep completes normally.
- wrap  output  1  one-cycle pulse when continuous mode wraps LAST -> 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sel=0, sel_en=0, busy=0, done=0, wrap=0, dwell counter=0, latched mode/dwell=0.
- Reset mid-sweep: outputs clear immediately, without waiting for a clock edge. After rst_n rises, the block waits in IDLE for a new start.
- All outputs are registered.
- States: IDLE and ACTIVE.
- IDLE -> ACTIVE on start=1 and stop=0 at edge k. At edge k: latch mode and dwell, set cnt=dwell, sel=0, sel_en=1, busy=1. So sel_en is visible one cycle after start is sampled.
- start and stop both high in IDLE: stop wins; the block stays in IDLE and no outputs change.
- ACTIVE hold: each index is held for dwell+1 cycles.
  - cnt decrements every cycle.
  - When cnt==0 and sel<LAST: sel increments and cnt reloads from the latched dwell.
- ACTIVE end of sweep, cnt==0 and sel==LAST:
  - Single mode: go to IDLE; sel=0, sel_en=0, busy=0, done=1 for exactly the first IDLE cycle.
  - Continuous mode: stay ACTIVE; sel=0, cnt reloads, wrap=1 for exactly one cycle coinciding with the sel=0 cycle.
- dwell=0: the index advances every cycle.
- dwell=all-ones: each index is held 2^DWELL_W cycles; no overflow.
- stop in ACTIVE: at the next edge go to IDLE; sel=0, sel_en=0, busy=0.
  - done is not pulsed and wrap is not pulsed.
  - stop overrides a coincident end-of-sweep or wrap event.
- start in ACTIVE is ignored; the latched mode and dwell are not updated.
- Changes to the mode or dwell inputs mid-sweep have no effect.
- sel never exceeds LAST.
- sel_en=1 implies busy=1.
- done and wrap are never high together and never high during reset.

Optional Feature:
- Macro: SCAN_SEQUENCER_PAUSE_EN.
- With the macro defined:
  - Adds input port pause (1 bit).
  - In ACTIVE with pause=1, the dwell counter and sel freeze; sel_en and busy stay 1.
  - Counting resumes on the first cycle pause=0.
  - stop still aborts while paused.
  - pause is ignored in IDLE.
- Without the macro: no pause port, and behaviour is exactly as above.

Test Plan:
- Reset with rst_n=0: all outputs 0.
  - Then assert rst_n low asynchronously mid-sweep with sel=7: sel=0 and sel_en=0 before the next clock edge.
- start=1, mode=0, dwell=0, LAST=15:
  - sel=0..15 on 16 consecutive cycles with sel_en=1.
  - Next cycle: sel_en=0, busy=0, done=1 for exactly 1 cycle.
- start=1, mode=0, dwell=2:
  - Each index held 3 cycles; sel_en high for 48 cycles.
  - done pulses once on cycle 49 after the first sel_en cycle.
- start=1, mode=1, dwell=1, run 70 cycles:
  - wrap pulses on the sel=0 cycles after each LAST hold (cycles 33 and 65 of the ACTIVE interval, counting from 1).
  - done never asserts.
- Mode=1 sweep at sel=9; assert stop=1 for 1 cycle:
  - Next cycle: sel_en=0, busy=0, sel=0, done=0, wrap=0.
- Corner cases:
  - start and stop together in IDLE: stays IDLE.
  - start during ACTIVE with changed dwell: hold time unchanged.
  - With SCAN_SEQUENCER_PAUSE_EN and pause=1 for 5 cycles at sel=4: sel stays 4 for hold+5 cycles.
